// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Assembles a byte stream into 16-bit instructions (high byte first) and
// queues the legal ones in a small FIFO for the downstream compute unit.
// Words whose opcode nibble is 4'b1000..4'b1111 are dropped and counted.
//
// Handshakes: a transfer happens on a cycle where valid && ready are both
// high at posedge clk. valid is never allowed to depend on ready, and once
// instr_valid is high, instr_out holds until the word is consumed.
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   byte_in      : incoming instruction byte (high byte, then low byte)
//   byte_valid   : byte_in is valid this cycle
//   byte_ready   : block accepts byte_in this cycle
//   instr_out    : FIFO head, {high byte, low byte}
//   instr_valid  : instr_out is valid (FIFO not empty)
//   instr_ready  : downstream consumes instr_out this cycle
//   level        : FIFO occupancy, 0..DEPTH
//   illegal_cnt  : saturating count of dropped illegal-opcode words
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 byte_in,
   input  logic                       byte_valid,
   output logic                       byte_ready,
   output logic [15:0]                instr_out,
   output logic                       instr_valid,
   input  logic                       instr_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic [7:0]                 illegal_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } asm_state_e;

   asm_state_e    state_q, state_d;
   logic [7:0]    hi_q, hi_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [7:0]    illegal_cnt_q, illegal_cnt_d;
   logic [15:0]   mem_q [DEPTH];

   logic          full;
   logic          byte_xfer;
   logic [15:0]   word;
   logic          push;
   logic          drop;
   logic          pop;

   always_comb begin
      full        = (level_q == LW'(DEPTH));
      // Full gates only the low byte: the high byte is always latched, and
      // no credit is taken for a pop happening in the same cycle.
      byte_ready  = (state_q == WAIT_HI) ? 1'b1 : !full;
      byte_xfer   = byte_valid && byte_ready;
      word        = {hi_q, byte_in};
      push        = byte_xfer && (state_q == WAIT_LO) && !word[15];
      drop        = byte_xfer && (state_q == WAIT_LO) &&  word[15];
      instr_valid = (level_q != '0);
      pop         = instr_valid && instr_ready;
      instr_out   = mem_q[rd_ptr_q];
      level       = level_q;
      illegal_cnt = illegal_cnt_q;
   end

   // Assembler next state
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      if (byte_xfer) begin
         if (state_q == WAIT_HI) begin
            hi_d    = byte_in;
            state_d = WAIT_LO;
         end else begin
            state_d = WAIT_HI;
         end
      end
   end

   // FIFO pointers, occupancy and illegal counter
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      illegal_cnt_d = illegal_cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      if (drop && (illegal_cnt_q != 8'hFF)) illegal_cnt_d = illegal_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= WAIT_HI;
         hi_q          <= 8'h00;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         illegal_cnt_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         hi_q          <= hi_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   // Storage is not reset; instr_out is only meaningful while instr_valid.
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= word;
   end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of 16-bit instruction FIFO entries (power of two, 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 Port: byte_in  input  8  instruction byte stream; high byte (opcode + target) first, then low byte (sources/immediate).
REQ-005 Port: byte_valid  input  1  byte_in carries a valid byte this cycle.
REQ-006 Port: byte_ready  output  1  block accepts byte_in this cycle.
REQ-007 Port: instr_out  output  16  instruction at FIFO head, {high byte, low byte}, for the downstream compute unit.
REQ-008 Port: instr_valid  output  1  instr_out holds a valid instruction.
REQ-009 Port: instr_ready  input  1  downstream consumes instr_out this cycle.
REQ-010 Port: level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-011 Port: illegal_cnt  output  8  count of dropped instructions with opcode 4'b1000..4'b1111, saturating.

Function
REQ-012 A byte transfer SHALL occur on a cycle with byte_valid && byte_ready; an instruction transfer on a cycle with instr_valid && instr_ready.
REQ-013 Assembler FSM SHALL have two states: WAIT_HI and WAIT_LO; reset state WAIT_HI.
REQ-014 In WAIT_HI: byte_ready = 1; on a byte transfer, byte_in SHALL be latched as the high byte and the FSM SHALL move to WAIT_LO.
REQ-015 In WAIT_LO: byte_ready = !full (full = level==DEPTH; no same-cycle pop credit); on a byte transfer, FSM SHALL return to WAIT_HI and the assembled word {hi, byte_in} SHALL be pushed.
REQ-016 Push filter: if assembled word[15:12] >= 4'b1000, the word SHALL NOT be written, and illegal_cnt SHALL increment by 1, holding at 8'hFF.
REQ-017 Opcodes 4'b0000..4'b0111 (including NOP 4'b0000) SHALL be written to the FIFO tail unmodified.
REQ-018 byte_valid low SHALL hold FSM state and latched high byte indefinitely; no timeout.
REQ-019 FIFO SHALL be first-in first-out, DEPTH entries, with read/write pointers wrapping modulo DEPTH.
REQ-020 instr_valid = (level != 0); instr_out = head entry, combinational from storage; instr_out value when empty is don't-care.
REQ-021 instr_out and instr_valid SHALL remain stable while instr_valid && !instr_ready.
REQ-022 Simultaneous push and pop, with the FIFO neither empty nor full, SHALL leave level unchanged and preserve order.
REQ-023 Pop with empty FIFO SHALL have no effect; push is impossible when full because byte_ready is low in WAIT_LO.
REQ-024 A dropped illegal word SHALL NOT change level or pointers, even when the FIFO is full. Full blocks the low byte before decode.
REQ-025 Latency: a legal instruction SHALL appear on instr_out with instr_valid high on the cycle after its low-byte transfer, when the FIFO was empty.
REQ-026 Sustained throughput: one instruction per two byte cycles; the pop side SHALL sustain one instruction per cycle.

Reset
REQ-027 On rst = 1 at posedge clk: FSM to WAIT_HI, pointers and level to 0, illegal_cnt to 0, latched high byte to 0.
REQ-028 After reset, outputs SHALL be: byte_ready = 1, instr_valid = 0, level = 0, illegal_cnt = 0. FIFO storage contents need not be cleared.
REQ-029 Reset asserted mid-instruction (FSM in WAIT_LO) SHALL discard the partial high byte. The next byte after reset SHALL be treated as a high byte.
REQ-030 rst SHALL take priority over any simultaneous byte or instruction transfer.

Verification
REQ-031 Stream 0x12,0x34 with instr_ready=0 -> one cycle after the second byte: instr_valid=1, instr_out=16'h1234, level=1.
REQ-032 Push DEPTH legal words with instr_ready=0 -> level=DEPTH. Next high byte accepted, then byte_ready=0 in WAIT_LO. Assert instr_ready one cycle -> byte_ready=1 the following cycle; order preserved.
REQ-033 Stream 0x9A,0xBC then 0x25,0x67 -> illegal_cnt=1, only 16'h2567 emerges, level never exceeds 1.
REQ-034 Fill to 2 entries, then present a byte every cycle with instr_ready=1 continuously -> level constant across simultaneous push/pop cycles, outputs in exact input order across pointer wrap (≥3·DEPTH words).
REQ-035 Send 0x31, assert rst next cycle, then send 0x14,0x0F -> single instruction 16'h140F, no 0x31-derived word.
REQ-036 Feed 256 illegal instructions -> illegal_cnt saturates at 8'hFF, level stays 0.
